// File: rtl/run_length_detector.sv
// Run-length detector for WIDTH-bit symbols with programmable threshold and pattern-match mode.
// Optional saturating run_start event counter enabled by defining RLD_EVENT_CNT_EN.
module run_length_detector #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 4,
  parameter int EVT_W = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] w,
  input  logic             mode,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] thresh,
  output logic             z,
  output logic [CNT_W-1:0] run_len,
  output logic             run_start,
  output logic             run_end,
  output logic [EVT_W-1:0] event_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;

  state_t           r_state;
  state_t           w_nxt_state;
  logic [WIDTH-1:0] r_last;
  logic [WIDTH-1:0] w_nxt_last;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] w_nxt_len;
  logic [CNT_W-1:0] w_eff_thresh;
  logic             w_qual;
  logic             r_z;
  logic             r_start;
  logic             r_end;

  always_comb begin
    w_eff_thresh = (thresh == '0) ? CNT_W'(1) : thresh;
    w_qual       = en & (~mode | (w == pattern));
    w_nxt_len    = r_len;
    w_nxt_last   = r_last;
    w_nxt_state  = r_state;
    if (en) begin
      if (!w_qual) begin
        w_nxt_len   = '0;
        w_nxt_state = IDLE;
      end else begin
        if (r_state == IDLE || w != r_last) begin
          w_nxt_len  = CNT_W'(1);
          w_nxt_last = w;
        end else if (r_len != '1) begin
          w_nxt_len = r_len + CNT_W'(1);
        end
        w_nxt_state = (w_nxt_len >= w_eff_thresh) ? HIT : RUN;
      end
    end else if (r_state != IDLE) begin
      // Without a sample the held run is re-judged against the live threshold
      w_nxt_state = (r_len >= w_eff_thresh) ? HIT : RUN;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= '0;
      r_len   <= '0;
      r_z     <= 1'b0;
      r_start <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_last  <= w_nxt_last;
      r_len   <= w_nxt_len;
      r_z     <= (w_nxt_state == HIT);
      r_start <= (w_nxt_state == HIT) && (r_state != HIT);
      r_end   <= (r_state == HIT) && (w_nxt_state != HIT);
    end
  end

  assign z         = r_z;
  assign run_len   = r_len;
  assign run_start = r_start;
  assign run_end   = r_end;

`ifdef RLD_EVENT_CNT_EN
  logic [EVT_W-1:0] r_evt;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_evt <= '0;
    end else if (r_start && (r_evt != '1)) begin
      r_evt <= r_evt + EVT_W'(1);
    end
  end

  assign event_cnt = r_evt;
`else
  assign event_cnt = '0;
`endif

endmodule

// File: tb/tb_run_length_detector.sv
// Self-checking bench for run_length_detector against a sample-history reference model.
module tb_run_length_detector;

  localparam int WIDTH  = 4;
  localparam int CNT_W  = 4;
  localparam int EVT_W  = 16;
  localparam int MAXLEN = (1 << CNT_W) - 1;
`ifdef RLD_EVENT_CNT_EN
  localparam bit EVT_ON = 1'b1;
`else
  localparam bit EVT_ON = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             rst   = 1'b0;
  logic             en    = 1'b0;
  logic [WIDTH-1:0] w     = '0;
  logic             mode  = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [CNT_W-1:0] thresh  = 4'd4;
  logic             z;
  logic [CNT_W-1:0] run_len;
  logic             run_start;
  logic             run_end;
  logic [EVT_W-1:0] event_cnt;

  run_length_detector #(.WIDTH(WIDTH), .CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
    .clock(clock), .rst(rst), .en(en), .w(w), .mode(mode), .pattern(pattern),
    .thresh(thresh), .z(z), .run_len(run_len), .run_start(run_start),
    .run_end(run_end), .event_cnt(event_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference: qualified symbols since the last disqualification/reset
  logic [WIDTH-1:0] hist[$];
  logic             exp_z, exp_start, exp_end;
  logic [CNT_W-1:0] exp_len;
  int               exp_evt;

  function automatic int trail_len();
    int n;
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size()-1]) break;
      n++;
    end
    return (n > MAXLEN) ? MAXLEN : n;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_z = 1'b0; exp_start = 1'b0; exp_end = 1'b0; exp_len = '0; exp_evt = 0;
  endtask

  task automatic step(input logic e, input logic [WIDTH-1:0] sym);
    int  n, eff;
    logic znew;
    @(negedge clock);
    en = e; w = sym;
    @(posedge clock);
    if (e) begin
      if (mode && sym != pattern) hist.delete();
      else begin
        hist.push_back(sym);
        if (hist.size() > MAXLEN) void'(hist.pop_front());
      end
    end
    n   = trail_len();
    eff = (thresh == 0) ? 1 : int'(thresh);
    znew = (n >= eff);
    exp_start = znew && !exp_z;
    exp_end   = !znew && exp_z;
    if (exp_start && exp_evt < (1 << EVT_W) - 1) exp_evt++;
    exp_z   = znew;
    exp_len = CNT_W'(n);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    model_reset();
    @(negedge clock);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({z, run_len, run_start, run_end, event_cnt} !== '0) begin
      errors++;
      $display("FAIL reset: z/len/start/end/evt=%b/%0d/%b/%b/%0d required all 0",
               z, run_len, run_start, run_end, event_cnt);
    end
    model_reset();
    @(negedge clock);
    rst = 1'b1;
  endtask

  task automatic test_basic_run();
    thresh = 4'd4; mode = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 4'h1);
      checks++;
      if ({z, run_len, run_start, run_end} !== {exp_z, exp_len, exp_start, exp_end}) begin
        errors++;
        $display("FAIL basic[%0d]: z/len/start/end=%b/%0d/%b/%b required %b/%0d/%b/%b",
                 i, z, run_len, run_start, run_end, exp_z, exp_len, exp_start, exp_end);
      end
      if (i == 3) begin
        checks++;
        if ({z, run_len, run_start} !== {1'b1, 4'd4, 1'b1}) begin
          errors++;
          $display("FAIL basic_hit: z/len/start=%b/%0d/%b required 1/4/1", z, run_len, run_start);
        end
      end
    end
    checks++;
    if ({z, run_len, run_start} !== {1'b1, 4'd15, 1'b0}) begin
      errors++;
      $display("FAIL basic_sat: z/len/start=%b/%0d/%b required 1/15/0", z, run_len, run_start);
    end
    step(1'b1, 4'h0);
    checks++;
    if ({z, run_len, run_start, run_end} !== {1'b0, 4'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_break: z/len/start/end=%b/%0d/%b/%b required 0/1/0/1",
               z, run_len, run_start, run_end);
    end
  endtask

  task automatic test_pattern_mode();
    mode = 1'b1; pattern = 4'h1; thresh = 4'd4;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i < 6) ? 4'h0 : 4'h1);
      checks++;
      if ({z, run_len, run_start, run_end} !== {exp_z, exp_len, exp_start, exp_end}) begin
        errors++;
        $display("FAIL pattern[%0d]: z/len/start/end=%b/%0d/%b/%b required %b/%0d/%b/%b",
                 i, z, run_len, run_start, run_end, exp_z, exp_len, exp_start, exp_end);
      end
    end
    checks++;
    if (z !== 1'b1 || run_len !== 4'd4) begin
      errors++;
      $display("FAIL pattern_hit: z/len=%b/%0d required 1/4", z, run_len);
    end
    mode = 1'b0;
  endtask

  task automatic test_en_gaps();
    logic             e_seq[6]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [WIDTH-1:0] w_seq[6]   = '{4'hA, 4'hA, 4'hA, 4'h5, 4'h3, 4'hA};
    thresh = 4'd4;
    for (int i = 0; i < 6; i++) begin
      step(e_seq[i], w_seq[i]);
      checks++;
      if ({z, run_len, run_start, run_end} !== {exp_z, exp_len, exp_start, exp_end}) begin
        errors++;
        $display("FAIL en_gap[%0d]: z/len/start/end=%b/%0d/%b/%b required %b/%0d/%b/%b",
                 i, z, run_len, run_start, run_end, exp_z, exp_len, exp_start, exp_end);
      end
    end
    checks++;
    if (z !== 1'b1 || run_len !== 4'd4) begin
      errors++;
      $display("FAIL en_gap_hit: z/len=%b/%0d required 1/4", z, run_len);
    end
  endtask

  task automatic test_thresh_change();
    thresh = 4'd4;
    for (int i = 0; i < 5; i++) step(1'b1, 4'h5);
    thresh = 4'd6;
    step(1'b0, 4'h0);
    checks++;
    if ({z, run_start, run_end} !== {1'b0, 1'b0, 1'b1} || exp_end !== 1'b1) begin
      errors++;
      $display("FAIL thresh_raise: z/start/end=%b/%b/%b required 0/0/1", z, run_start, run_end);
    end
    thresh = 4'd0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, (i % 2 == 0) ? 4'h3 : 4'hC);
      checks++;
      if ({z, run_len, run_start, run_end} !== {exp_z, exp_len, exp_start, exp_end} || z !== 1'b1) begin
        errors++;
        $display("FAIL thresh_zero[%0d]: z/len/start/end=%b/%0d/%b/%b required %b/%0d/%b/%b",
                 i, z, run_len, run_start, run_end, 1'b1, exp_len, exp_start, exp_end);
      end
    end
  endtask

  task automatic test_async_reset();
    thresh = 4'd4; mode = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 4'h7);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({z, run_len, run_start, run_end, event_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset: z/len/start/end/evt=%b/%0d/%b/%b/%0d required all 0",
               z, run_len, run_start, run_end, event_cnt);
    end
    model_reset();
    @(negedge clock);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'h0);
      checks++;
      if ({z, run_len, run_start, run_end} !== {exp_z, exp_len, exp_start, exp_end}) begin
        errors++;
        $display("FAIL post_reset[%0d]: z/len/start/end=%b/%0d/%b/%b required %b/%0d/%b/%b",
                 i, z, run_len, run_start, run_end, exp_z, exp_len, exp_start, exp_end);
      end
    end
  endtask

  task automatic test_events();
    pulse_reset();
    thresh = 4'd2; mode = 1'b1; pattern = 4'h6;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        step(1'b1, (i < 3) ? 4'h6 : 4'h1);
        checks++;
        if ({z, run_len, run_start, run_end} !== {exp_z, exp_len, exp_start, exp_end}) begin
          errors++;
          $display("FAIL events[%0d.%0d]: z/len/start/end=%b/%0d/%b/%b required %b/%0d/%b/%b",
                   r, i, z, run_len, run_start, run_end, exp_z, exp_len, exp_start, exp_end);
        end
      end
    end
    step(1'b0, 4'h0);
    checks++;
    if (event_cnt !== (EVT_ON ? EVT_W'(exp_evt) : '0) || exp_evt != 3) begin
      errors++;
      $display("FAIL event_count: event_cnt=%0d required %0d", event_cnt, EVT_ON ? exp_evt : 0);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (event_cnt !== '0) begin
      errors++;
      $display("FAIL event_reset: event_cnt=%0d required 0", event_cnt);
    end
    model_reset();
    @(negedge clock);
    rst = 1'b1;
    mode = 1'b0;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] sym;
    sym = 4'h0;
    for (int i = 0; i < 500; i++) begin
      if (i % 40 == 0) begin
        thresh  = CNT_W'($urandom_range(0, 7));
        mode    = ($urandom_range(0, 3) == 0);
        pattern = WIDTH'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 4) == 0) sym = WIDTH'($urandom_range(0, 2));
      step($urandom_range(0, 5) != 0, sym);
      checks++;
      if ({z, run_len, run_start, run_end} !== {exp_z, exp_len, exp_start, exp_end}) begin
        errors++;
        $display("FAIL random[%0d]: z/len/start/end=%b/%0d/%b/%b required %b/%0d/%b/%b",
                 i, z, run_len, run_start, run_end, exp_z, exp_len, exp_start, exp_end);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_run();
    test_pattern_mode();
    test_en_gaps();
    test_thresh_change();
    test_async_reset();
    test_events();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
